// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the fetch front-end: the queue-entry layout,
// the reset PC default, the PC increment helper and the base opcode encodings.
package inst_fetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } iq_entry_t;

  localparam int unsigned IQ_ENTRY_W = $bits(iq_entry_t);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b000_0011,
    OPC_OP_IMM = 7'b001_0011,
    OPC_AUIPC  = 7'b001_0111,
    OPC_STORE  = 7'b010_0011,
    OPC_OP     = 7'b011_0011,
    OPC_LUI    = 7'b011_0111,
    OPC_BRANCH = 7'b110_0011,
    OPC_JALR   = 7'b110_0111,
    OPC_JAL    = 7'b110_1111
  } opcode_e;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Synchronous FIFO with push/pop/clear and occupancy count; a power-of-two depth
// lets the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: every signal assigned in always_comb gets its default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front-end: owns the PC, issues credit-limited reads to a 1-cycle imem,
// queues returned words with their PCs and redirects on flush.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        dispatch_rd,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        empty,
  output logic        full
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      pc_q, pc_d, req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credit_used;
  logic             issue, push, pop;
  iq_entry_t        wr_entry, head_entry;

  // Reserving a slot for the in-flight word guarantees every return has space.
  assign credit_used = {1'b0, count} + (CNT_W + 1)'(inflight_q);
  assign issue       = !flush && (credit_used < (CNT_W + 1)'(DEPTH));
  assign push        = inflight_q && !flush;
  assign pop         = dispatch_rd && inst_valid && !flush;
  assign wr_entry    = '{pc: req_pc_q, instr: imem_data};

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (flush) begin
      pc_d = flush_pc;
    end else if (issue) begin
      pc_d     = next_pc(pc_q);
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  sync_fifo #(
    .WIDTH (IQ_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );

  assign imem_rd_en  = issue;
  assign imem_addr   = pc_q;
  assign inst_valid  = !empty;
  assign instruction = head_entry.instr;
  assign inst_pc     = head_entry.pc;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed phases queue expected dispatches,
// a negedge monitor pops and compares every accepted head entry.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, dispatch_rd;
  logic [31:0] flush_pc;
  logic        imem_rd_en, inst_valid, empty, full;
  logic [31:0] imem_addr, instruction, inst_pc;
  logic [31:0] imem_data = 32'h0;
  logic        tb_inflight = 1'b0;

  int          n_vec  = 0;
  int          n_miss = 0;
  iq_entry_t   exp_q[$];
  iq_entry_t   mon_e;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .dispatch_rd (dispatch_rd),
    .inst_valid  (inst_valid),
    .instruction (instruction),
    .inst_pc     (inst_pc),
    .empty       (empty),
    .full        (full)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // One-cycle synchronous instruction memory; garbage when not read.
  always @(posedge clk) imem_data <= imem_rd_en ? mem_word(imem_addr) : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_seq(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{pc: first + 32'(4 * i), instr: mem_word(first + 32'(4 * i))});
  endtask

  // Monitor: every accepted dispatch must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && !flush && dispatch_rd && inst_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_pop: got pc %h, expected no dispatch", inst_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_pc", inst_pc, mon_e.pc);
        check("pop_instr", instruction, mon_e.instr);
      end
    end
  end

  // A returning word must never land in a full queue.
  always @(posedge clk) begin
    if (rst_n && tb_inflight && !flush && full) begin
      n_vec++;
      n_miss++;
      $display("FAIL overflow: got push with full=1, expected no push");
    end
    tb_inflight <= rst_n && imem_rd_en;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    dispatch_rd = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] ea;
    rst_n = 1'b0;
    flush = 1'b0;
    flush_pc = 32'h0000_0100;
    dispatch_rd = 1'b0;

    // Free run with dispatch held high from reset: also covers pop-while-empty.
    do_reset();
    dispatch_rd = 1'b1;
    expect_seq(32'h0, 10);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("a_addr", imem_addr, 32'(4 * k));
      check("a_rd_en", 32'(imem_rd_en), 32'd1);
      if (k == 0) begin
        check("rst_full", 32'(full), 32'd0);
        check("rst_instr", instruction, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
      end
      if (k < 2) begin
        check("a_empty", 32'(empty), 32'd1);
        check("a_valid", 32'(inst_valid), 32'd0);
      end else begin
        check("a_valid", 32'(inst_valid), 32'd1);
      end
      step();
    end
    drain("a_drain");

    // Fill to full with no dispatch, then stream out across pointer wrap.
    do_reset();
    expect_seq(32'h0, 12);
    for (int k = 0; k < 20; k++) begin
      dispatch_rd = (k >= 8);
      @(negedge clk);
      if (k <= 3)      ea = 32'(4 * k);
      else if (k <= 9) ea = 32'h10;
      else             ea = 32'(16 + 4 * (k - 9));
      check("b_addr", imem_addr, ea);
      check("b_rd_en", 32'(imem_rd_en), 32'((k <= 3) || (k >= 9)));
      check("b_full", 32'(full), 32'((k >= 5) && (k <= 8)));
      check("b_valid", 32'(inst_valid), 32'(k >= 2));
      if (k == 7) check("b_head_pc", inst_pc, 32'h0);
      step();
    end
    drain("b_drain");

    // Flush at cycle 6 to 0x100 while streaming: 0x10/0x14/0x18 must never dispatch.
    do_reset();
    dispatch_rd = 1'b1;
    expect_seq(32'h0, 4);
    expect_seq(32'h100, 4);
    for (int k = 0; k < 13; k++) begin
      flush = (k == 6);
      @(negedge clk);
      if (k == 6) check("c_rd_en_flush", 32'(imem_rd_en), 32'd0);
      if (k == 7) begin
        check("c_valid_t1", 32'(inst_valid), 32'd0);
        check("c_empty_t1", 32'(empty), 32'd1);
        check("c_rd_en_t1", 32'(imem_rd_en), 32'd1);
        check("c_addr_t1", imem_addr, 32'h100);
        check("c_instr_t1", instruction, 32'h0);
        check("c_inst_pc_t1", inst_pc, 32'h0);
      end
      if (k == 8) begin
        check("c_valid_t2", 32'(inst_valid), 32'd0);
        check("c_addr_t2", imem_addr, 32'h104);
      end
      if (k == 9) check("c_valid_t3", 32'(inst_valid), 32'd1);
      step();
    end
    flush = 1'b0;
    drain("c_drain");

    // Reset mid-stream with three entries queued and a word in flight.
    do_reset();
    expect_seq(32'h0, 2);
    for (int k = 0; k < 9; k++) begin
      rst_n = !(k == 4);
      dispatch_rd = (k >= 5);
      @(negedge clk);
      if (k == 4) begin
        check("f_valid_pre", 32'(inst_valid), 32'd1);
        check("f_head_pre", inst_pc, 32'h0);
        check("f_full_pre", 32'(full), 32'd0);
        check("f_rd_en_pre", 32'(imem_rd_en), 32'd0);
      end
      if (k == 5) begin
        check("f_valid_post", 32'(inst_valid), 32'd0);
        check("f_empty_post", 32'(empty), 32'd1);
        check("f_addr_post", imem_addr, 32'h0);
        check("f_rd_en_post", 32'(imem_rd_en), 32'd1);
        check("f_inst_pc_post", inst_pc, 32'h0);
      end
      step();
    end
    drain("f_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
